// File: rtl/duck_hunt_pkg.sv
// Shared constants for the bird plot engine: sprite length, wing offsets, FSM states.
// Latency: none (constants only).
// Backpressure: none.
package duck_hunt_pkg;

    localparam int SPRITE_LEN = 13;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        ERASE = 3'd2,
        DRAW  = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Offset tables, element k holds the offset for sprite pixel k (leftmost entry is k=12).
    // Phase 0 has the wings swept back; phase 1 pulls the outer wing pixels forward.
    localparam logic [SPRITE_LEN-1:0][3:0] SPR_DX_P0 = {
        -4'sd5, -4'sd5, -4'sd4, -4'sd4, -4'sd3, -4'sd3,
        -4'sd5, -4'sd4, -4'sd3, -4'sd2, -4'sd1, 4'sd0, 4'sd0
    };
    localparam logic [SPRITE_LEN-1:0][3:0] SPR_DY_P0 = {
        -4'sd3, 4'sd3, -4'sd2, 4'sd2, -4'sd1, 4'sd1,
        4'sd0, 4'sd0, 4'sd0, 4'sd0, 4'sd0, 4'sd1, 4'sd0
    };
    localparam logic [SPRITE_LEN-1:0][3:0] SPR_DX_P1 = {
        -4'sd1, -4'sd1, -4'sd2, -4'sd2, -4'sd3, -4'sd3,
        -4'sd5, -4'sd4, -4'sd3, -4'sd2, -4'sd1, 4'sd0, 4'sd0
    };
    localparam logic [SPRITE_LEN-1:0][3:0] SPR_DY_P1 = SPR_DY_P0;

endpackage

// File: rtl/bird_sprite_rom.sv
// Sprite offset lookup: (pixel index, wing phase) -> signed (dx, dy).
// Latency: combinational.
// Backpressure: none.
module bird_sprite_rom
    import duck_hunt_pkg::*;
(
    input  logic [3:0]        k_i,
    input  logic              phase_i,
    output logic signed [3:0] dx_o,
    output logic signed [3:0] dy_o
);

    // Table read; indices past the sprite length return a zero offset.
    always_comb begin
        dx_o = 4'sd0;
        dy_o = 4'sd0;
        if (k_i < 4'(SPRITE_LEN)) begin
            dx_o = phase_i ? SPR_DX_P1[k_i] : SPR_DX_P0[k_i];
            dy_o = phase_i ? SPR_DY_P1[k_i] : SPR_DY_P0[k_i];
        end
    end

endmodule

// File: rtl/bird_plotter.sv
// Per frame tick: erase every previously drawn bird, then draw every active bird, one pixel/clock.
// Latency: done pulses 2+Ce+Cd clocks after start is accepted (13 clocks per active bird, 1 per idle).
// Backpressure: none; start is ignored while busy. Optional feature macro: WING_FLAP_EN.
module bird_plotter
    import duck_hunt_pkg::*;
#(
    parameter int         NUM_BIRDS = 4,
    parameter int         X_W       = 8,
    parameter int         Y_W       = 7,
    parameter int         SCREEN_W  = 160,
    parameter int         SCREEN_H  = 120,
    parameter logic [2:0] FG_COLOUR = 3'b111,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     start,
    input  logic [NUM_BIRDS*X_W-1:0] bird_x,
    input  logic [NUM_BIRDS*Y_W-1:0] bird_y,
    input  logic [NUM_BIRDS-1:0]     bird_active,
    output logic [X_W-1:0]           x,
    output logic [Y_W-1:0]           y,
    output logic [2:0]               colour,
    output logic                     plot,
    output logic                     busy,
    output logic                     done
);

    localparam int            BW         = (NUM_BIRDS > 1) ? $clog2(NUM_BIRDS) : 1;
    localparam logic [BW-1:0] LAST_BIRD  = BW'(NUM_BIRDS - 1);
    localparam logic [3:0]    LAST_K     = 4'(SPRITE_LEN - 1);
    localparam logic [X_W:0]  SCREEN_W_V = (X_W + 1)'(SCREEN_W);
    localparam logic [Y_W:0]  SCREEN_H_V = (Y_W + 1)'(SCREEN_H);

    state_e                   state_q;
    logic [BW-1:0]            bird_q;
    logic [3:0]               k_q;
    logic [NUM_BIRDS*X_W-1:0] old_x_q, new_x_q;
    logic [NUM_BIRDS*Y_W-1:0] old_y_q, new_y_q;
    logic [NUM_BIRDS-1:0]     old_act_q, new_act_q;
    logic [X_W-1:0]           x_q;
    logic [Y_W-1:0]           y_q;
    logic [2:0]               colour_q;
    logic                     plot_q, busy_q, done_q;

    logic                     erase_w;
    logic [X_W-1:0]           cur_x_d;
    logic [Y_W-1:0]           cur_y_d;
    logic                     cur_act_d;
    logic                     cur_phase_d;
    logic signed [3:0]        dx_d, dy_d;
    logic signed [X_W:0]      px_d;
    logic signed [Y_W:0]      py_d;
    logic                     on_screen_d;

    assign erase_w = (state_q == ERASE);

`ifdef WING_FLAP_EN
    // Wing phase flips each frame; each set remembers the phase it was drawn with.
    logic phase_q, new_phase_q, old_phase_q;
    assign cur_phase_d = erase_w ? old_phase_q : new_phase_q;
`else
    assign cur_phase_d = 1'b0;
`endif

    // Select the current bird's position/activity from the old set (erase) or new set (draw).
    always_comb begin
        cur_x_d   = '0;
        cur_y_d   = '0;
        cur_act_d = 1'b0;
        for (int b = 0; b < NUM_BIRDS; b++) begin
            if (bird_q == BW'(b)) begin
                cur_x_d   = erase_w ? old_x_q[b*X_W +: X_W] : new_x_q[b*X_W +: X_W];
                cur_y_d   = erase_w ? old_y_q[b*Y_W +: Y_W] : new_y_q[b*Y_W +: Y_W];
                cur_act_d = erase_w ? old_act_q[b] : new_act_q[b];
            end
        end
    end

    bird_sprite_rom u_rom (
        .k_i     (k_q),
        .phase_i (cur_phase_d),
        .dx_o    (dx_d),
        .dy_o    (dy_d)
    );

    // Signed pixel position with one extra bit so off-screen pixels are clipped, never wrapped.
    always_comb begin
        px_d        = $signed({1'b0, cur_x_d}) + (X_W + 1)'(dx_d);
        py_d        = $signed({1'b0, cur_y_d}) + (Y_W + 1)'(dy_d);
        on_screen_d = !px_d[X_W] && ($unsigned(px_d) < SCREEN_W_V) &&
                      !py_d[Y_W] && ($unsigned(py_d) < SCREEN_H_V);
    end

    // Frame sequencer: latch sets, walk erase then draw, registered pixel bus and status.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            bird_q    <= '0;
            k_q       <= '0;
            old_x_q   <= '0;
            old_y_q   <= '0;
            old_act_q <= '0;
            new_x_q   <= '0;
            new_y_q   <= '0;
            new_act_q <= '0;
            x_q       <= '0;
            y_q       <= '0;
            colour_q  <= '0;
            plot_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef WING_FLAP_EN
            phase_q     <= 1'b0;
            new_phase_q <= 1'b0;
            old_phase_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            plot_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) state_q <= LATCH;
                end
                LATCH: begin
                    old_x_q   <= new_x_q;
                    old_y_q   <= new_y_q;
                    old_act_q <= new_act_q;
                    new_x_q   <= bird_x;
                    new_y_q   <= bird_y;
                    new_act_q <= bird_active;
`ifdef WING_FLAP_EN
                    old_phase_q <= new_phase_q;
                    new_phase_q <= phase_q;
`endif
                    bird_q  <= '0;
                    k_q     <= '0;
                    busy_q  <= 1'b1;
                    state_q <= ERASE;
                end
                ERASE, DRAW: begin
                    x_q      <= px_d[X_W-1:0];
                    y_q      <= py_d[Y_W-1:0];
                    colour_q <= erase_w ? BG_COLOUR : FG_COLOUR;
                    plot_q   <= cur_act_d && on_screen_d;
                    if (cur_act_d && (k_q != LAST_K)) begin
                        k_q <= k_q + 4'd1;
                    end else begin
                        k_q <= '0;
                        if (bird_q == LAST_BIRD) begin
                            bird_q  <= '0;
                            state_q <= erase_w ? DRAW : DONE;
                        end else begin
                            bird_q <= bird_q + BW'(1);
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
`ifdef WING_FLAP_EN
                    phase_q <= ~phase_q;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_bird_plotter.sv
// Self-checking bench for bird_plotter against a frame-level pixel list model.
// Latency: checks done timing relative to the accepted start edge.
// Backpressure: exercises start while busy and reset mid-frame.
module tb_bird_plotter;

    localparam int NB = 4;
    localparam int XW = 8;
    localparam int YW = 7;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [2:0]    c;
    } pix_t;

    logic             clock = 1'b0;
    logic             resetn = 1'b1;
    logic             start = 1'b0;
    logic [NB*XW-1:0] bird_x = '0;
    logic [NB*YW-1:0] bird_y = '0;
    logic [NB-1:0]    bird_active = '0;
    logic [XW-1:0]    x;
    logic [YW-1:0]    y;
    logic [2:0]       colour;
    logic             plot, busy, done;

    int checks = 0;
    int errors = 0;

    pix_t obs_q[$];
    pix_t exp_q[$];
    int   lat, exp_lat, m_ce;
    logic busy_first, busy_gap, busy_at_done;

    int m_old_x[NB], m_old_y[NB], m_new_x[NB], m_new_y[NB];
    bit m_old_act[NB], m_new_act[NB];
    int m_phase, m_old_ph, m_new_ph;

    int DX0[13] = '{0, 0, -1, -2, -3, -4, -5, -3, -3, -4, -4, -5, -5};
    int DX1[13] = '{0, 0, -1, -2, -3, -4, -5, -3, -3, -2, -2, -1, -1};
    int DY [13] = '{0, 1, 0, 0, 0, 0, 0, 1, -1, 2, -2, 3, -3};

    bird_plotter #(
        .NUM_BIRDS (NB),
        .X_W       (XW),
        .Y_W       (YW)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .start       (start),
        .bird_x      (bird_x),
        .bird_y      (bird_y),
        .bird_active (bird_active),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .plot        (plot),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    function automatic void model_reset();
        for (int b = 0; b < NB; b++) begin
            m_old_x[b] = 0; m_old_y[b] = 0; m_new_x[b] = 0; m_new_y[b] = 0;
            m_old_act[b] = 0; m_new_act[b] = 0;
        end
        m_phase = 0; m_old_ph = 0; m_new_ph = 0;
    endfunction

    function automatic void add_sprite(int bx, int by, int ph, logic [2:0] c);
        int px, py;
        for (int k = 0; k < 13; k++) begin
            px = bx + ((ph != 0) ? DX1[k] : DX0[k]);
            py = by + DY[k];
            if (px >= 0 && px < 160 && py >= 0 && py < 120)
                exp_q.push_back('{x: XW'(px), y: YW'(py), c: c});
        end
    endfunction

    function automatic void model_frame(logic [NB*XW-1:0] bx, logic [NB*YW-1:0] by,
                                        logic [NB-1:0] act);
        int cd;
        exp_q.delete();
        m_ce = 0;
        cd = 0;
        for (int b = 0; b < NB; b++) begin
            m_old_x[b] = m_new_x[b]; m_old_y[b] = m_new_y[b]; m_old_act[b] = m_new_act[b];
            m_new_x[b] = int'(bx[b*XW +: XW]);
            m_new_y[b] = int'(by[b*YW +: YW]);
            m_new_act[b] = act[b];
        end
        m_old_ph = m_new_ph;
        m_new_ph = m_phase;
        for (int b = 0; b < NB; b++) begin
            if (m_old_act[b]) begin m_ce += 13; add_sprite(m_old_x[b], m_old_y[b], m_old_ph, 3'b000); end
            else m_ce += 1;
        end
        for (int b = 0; b < NB; b++) begin
            if (m_new_act[b]) begin cd += 13; add_sprite(m_new_x[b], m_new_y[b], m_new_ph, 3'b111); end
            else cd += 1;
        end
        exp_lat = 2 + m_ce + cd;
`ifdef WING_FLAP_EN
        m_phase = 1 - m_phase;
`endif
    endfunction

    function automatic int diff_idx();
        int n;
        n = (obs_q.size() > exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (i >= obs_q.size() || i >= exp_q.size() || obs_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    function automatic string pix_str(bit from_obs, int i);
        pix_t p;
        if (from_obs) begin
            if (i >= obs_q.size()) return "none";
            p = obs_q[i];
        end else begin
            if (i >= exp_q.size()) return "none";
            p = exp_q[i];
        end
        return $sformatf("(%0d,%0d,c%0d)", p.x, p.y, p.c);
    endfunction

    function automatic int count_colour(logic [2:0] c);
        int n = 0;
        foreach (obs_q[i]) if (obs_q[i].c == c) n++;
        return n;
    endfunction

    // Drive one frame tick and record every plotted pixel until done (bounded).
    task automatic run_frame(input logic [NB*XW-1:0] bx, input logic [NB*YW-1:0] by,
                             input logic [NB-1:0] act, input int poke_at);
        obs_q.delete();
        lat = -1; busy_first = 1'b0; busy_gap = 1'b0; busy_at_done = 1'b1;
        model_frame(bx, by, act);
        @(negedge clock);
        bird_x = bx; bird_y = by; bird_active = act; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clock); #1;
            bird_x = (NB*XW)'($urandom);
            bird_y = (NB*YW)'($urandom);
            bird_active = NB'($urandom);
            start = (n == poke_at);
            if (n == 1) busy_first = busy;
            if (plot) obs_q.push_back('{x: x, y: y, c: colour});
            if (done) begin lat = n; busy_at_done = busy; break; end
            if (!busy) busy_gap = 1'b1;
        end
        start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2 resetn = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if ({x, y, colour, plot, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got x=%0d y=%0d c=%0d plot=%b busy=%b done=%b, expected all 0",
                     x, y, colour, plot, busy, done);
        end
        model_reset();
        @(negedge clock) resetn = 1'b1;
    endtask

    task automatic test_single_bird();
        int d;
        run_frame({24'($urandom), 8'd80}, {21'($urandom), 7'd60}, 4'b0001, 0);
        checks++;
        if (lat !== 22) begin errors++; $display("FAIL single_latency got %0d expected 22", lat); end
        checks++; d = diff_idx();
        if (d != -1) begin errors++; $display("FAIL single_pixels idx %0d got %s expected %s", d, pix_str(1, d), pix_str(0, d)); end
        checks++;
        if (count_colour(3'b000) !== 0) begin errors++; $display("FAIL single_bg_count got %0d expected 0", count_colour(3'b000)); end
        checks++;
        if (busy_first !== 1'b1) begin errors++; $display("FAIL busy_rise got %b expected 1", busy_first); end
        checks++;
        if (busy_gap !== 1'b0) begin errors++; $display("FAIL busy_hold got gap=%b expected 0", busy_gap); end
        checks++;
        if (busy_at_done !== 1'b0) begin errors++; $display("FAIL busy_fall got %b expected 0", busy_at_done); end
    endtask

    task automatic test_second_frame();
        int d;
        run_frame({24'd0, 8'd81}, {21'd0, 7'd60}, 4'b0001, 0);
        checks++;
        if (lat !== exp_lat) begin errors++; $display("FAIL second_latency got %0d expected %0d", lat, exp_lat); end
        checks++; d = diff_idx();
        if (d != -1) begin errors++; $display("FAIL second_pixels idx %0d got %s expected %s", d, pix_str(1, d), pix_str(0, d)); end
        checks++;
        if (count_colour(3'b000) !== 13) begin errors++; $display("FAIL second_bg_count got %0d expected 13", count_colour(3'b000)); end
    endtask

    task automatic test_clip();
        int d;
        run_frame({24'd0, 8'd2}, {21'd0, 7'd1}, 4'b0001, 0);
        checks++;
        if (lat !== exp_lat) begin errors++; $display("FAIL clip_latency got %0d expected %0d", lat, exp_lat); end
        checks++; d = diff_idx();
        if (d != -1) begin errors++; $display("FAIL clip_pixels idx %0d got %s expected %s", d, pix_str(1, d), pix_str(0, d)); end
        checks++;
        if (count_colour(3'b111) !== 4) begin errors++; $display("FAIL clip_fg_count got %0d expected 4", count_colour(3'b111)); end
    endtask

    task automatic test_random();
        int d;
        logic [NB*XW-1:0] bx;
        logic [NB*YW-1:0] by;
        for (int f = 0; f < 8; f++) begin
            for (int b = 0; b < NB; b++) begin
                bx[b*XW +: XW] = XW'($urandom_range(0, 175));
                by[b*YW +: YW] = YW'($urandom_range(0, 127));
            end
            run_frame(bx, by, NB'($urandom), 0);
            checks++;
            if (lat !== exp_lat) begin errors++; $display("FAIL random%0d_latency got %0d expected %0d", f, lat, exp_lat); end
            checks++; d = diff_idx();
            if (d != -1) begin errors++; $display("FAIL random%0d_pixels idx %0d got %s expected %s", f, d, pix_str(1, d), pix_str(0, d)); end
        end
    endtask

    task automatic test_busy_start();
        int d, extra;
        run_frame({8'd40, 8'd100, 8'd20, 8'd150}, {7'd30, 7'd90, 7'd10, 7'd119}, 4'b1011, 5);
        checks++;
        if (lat !== exp_lat) begin errors++; $display("FAIL busy_start_latency got %0d expected %0d", lat, exp_lat); end
        checks++; d = diff_idx();
        if (d != -1) begin errors++; $display("FAIL busy_start_pixels idx %0d got %s expected %s", d, pix_str(1, d), pix_str(0, d)); end
        extra = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (busy || done) extra++;
        end
        checks++;
        if (extra !== 0) begin errors++; $display("FAIL busy_start_extra got %0d busy/done cycles expected 0", extra); end
        run_frame({8'd10, 8'd60, 8'd70, 8'd5}, {7'd20, 7'd50, 7'd60, 7'd5}, 4'b0110, 0);
        checks++; d = diff_idx();
        if (d != -1) begin errors++; $display("FAIL busy_start_next_pixels idx %0d got %s expected %s", d, pix_str(1, d), pix_str(0, d)); end
    endtask

    task automatic test_reset_mid();
        int d;
        model_frame({8'd50, 8'd60, 8'd70, 8'd80}, {7'd40, 7'd50, 7'd60, 7'd70}, 4'b1111);
        @(negedge clock);
        bird_x = {8'd50, 8'd60, 8'd70, 8'd80}; bird_y = {7'd40, 7'd50, 7'd60, 7'd70};
        bird_active = 4'b1111; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (m_ce + 4) @(posedge clock);
        #1 resetn = 1'b0;
        #1;
        checks++;
        if ({plot, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid got plot=%b busy=%b done=%b expected 000", plot, busy, done);
        end
        model_reset();
        @(negedge clock) resetn = 1'b1;
        run_frame({24'd0, 8'd80}, {21'd0, 7'd60}, 4'b0001, 0);
        checks++;
        if (count_colour(3'b000) !== 0) begin errors++; $display("FAIL reset_mid_bg_count got %0d expected 0", count_colour(3'b000)); end
        checks++; d = diff_idx();
        if (d != -1) begin errors++; $display("FAIL reset_mid_pixels idx %0d got %s expected %s", d, pix_str(1, d), pix_str(0, d)); end
        checks++;
        if (lat !== exp_lat) begin errors++; $display("FAIL reset_mid_latency got %0d expected %0d", lat, exp_lat); end
    endtask

`ifdef WING_FLAP_EN
    task automatic test_wing_flap();
        int d;
        @(negedge clock) resetn = 1'b0;
        model_reset();
        @(negedge clock) resetn = 1'b1;
        run_frame({24'd0, 8'd80}, {21'd0, 7'd60}, 4'b0001, 0);
        run_frame({24'd0, 8'd80}, {21'd0, 7'd60}, 4'b0001, 0);
        checks++;
        if (obs_q.size() < 23 || obs_q[22] !== '{x: 8'd78, y: 7'd62, c: 3'b111}) begin
            errors++;
            $display("FAIL wing_pixel9 got %s expected (78,62,c7)", pix_str(1, 22));
        end
        run_frame({24'd0, 8'd80}, {21'd0, 7'd60}, 4'b0001, 0);
        checks++; d = diff_idx();
        if (d != -1) begin errors++; $display("FAIL wing_erase_pixels idx %0d got %s expected %s", d, pix_str(1, d), pix_str(0, d)); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_bird();
        test_second_frame();
        test_clip();
        test_random();
        test_busy_start();
        test_reset_mid();
`ifdef WING_FLAP_EN
        test_wing_flap();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bird_plotter.md
Name: bird_plotter

Overview:
Multi-bird sprite plot engine for the 160x120 VGA frame buffer. On each frame tick it erases every bird drawn in the previous frame, then draws every currently active bird. It emits one pixel per clock on the x/y/colour/plot bus of vga_adapter. It sits between the game controller, which supplies positions and an active mask, and vga_adapter.

Parameters:
NUM_BIRDS, 4, number of bird channels (1..16).
X_W, 8, x coordinate width.
Y_W, 7, y coordinate width.
SCREEN_W, 160, visible columns; pixels with x >= SCREEN_W are clipped.
SCREEN_H, 120, visible rows; pixels with y >= SCREEN_H are clipped.
FG_COLOUR, 3'b111, draw colour.
BG_COLOUR, 3'b000, erase colour.

Ports:
clock  in  1  system clock (CLOCK_50 domain).
resetn  in  1  asynchronous, active-low reset.
start  in  1  frame tick; sampled only in IDLE.
bird_x  in  NUM_BIRDS*X_W  packed x positions; bird b occupies bits [b*X_W +: X_W].
bird_y  in  NUM_BIRDS*Y_W  packed y positions.
bird_active  in  NUM_BIRDS  bit b set means bird b is drawn this frame.
x  out  X_W  pixel x to vga_adapter.
y  out  Y_W  pixel y to vga_adapter.
colour  out  3  pixel colour.
plot  out  1  pixel write strobe.
busy  out  1  high from start acceptance until done.
done  out  1  one-cycle pulse at the end of a frame update.

Behaviour:
- Reset is asynchronous and active-low. While resetn is low: x=0, y=0, colour=0, plot=0, busy=0, done=0, state=IDLE, and the stored old positions and old mask are 0. If reset is asserted mid-operation, the operation aborts immediately and the next frame erases nothing.
- States:
  - IDLE: on start=1, go to LATCH. busy=0.
  - LATCH (1 cycle): copy the previous "new" set (positions, mask) into the old set; capture bird_x, bird_y and bird_active into the new set. Go to ERASE at bird 0, pixel 0.
  - ERASE: walk birds 0..NUM_BIRDS-1 using the old set.
  - DRAW: walk birds 0..NUM_BIRDS-1 using the new set.
  - DONE (1 cycle): go to IDLE.
- Per-bird timing: an active bird takes 13 cycles, pixels k=0..12. An inactive bird takes 1 cycle with plot=0.
- Inputs are ignored outside LATCH. start is ignored while busy=1.
- Sprite offsets (dx,dy) for k=0..12:
  - k=0..6: (0,0) (0,+1) (-1,0) (-2,0) (-3,0) (-4,0) (-5,0).
  - k=7..12: (-3,+1) (-3,-1) (-4,+2) (-4,-2) (-5,+3) (-5,-3).
- Arithmetic: compute px = x+dx and py = y+dy in signed X_W+1 / Y_W+1 bits. If px<0, px>=SCREEN_W, py<0 or py>=SCREEN_H, force plot=0; the cycle is still consumed. No wrap-around.
- Outputs are registered. The pixel for sequencer position (b,k) appears on the outputs one clock after the sequencer is at (b,k). colour is BG_COLOUR in ERASE and FG_COLOUR in DRAW.
- Latency: start is sampled at clock edge E0. done=1 during the cycle following edge E0+2+Ce+Cd, where Ce = sum over birds of (13 if old-active else 1), and Cd is the same sum using the new mask.
- busy rises at edge E0+1 and falls together with the done pulse.

Optional Feature:
WING_FLAP_EN
- Defined: a phase bit toggles at each DONE. When phase=1, offsets k=7..12 become (-3,+1) (-3,-1) (-2,+2) (-2,-2) (-1,+3) (-1,-3). The phase used for each bird is stored with the new set, and ERASE uses the stored phase.
- Undefined: phase is constant 0 and no phase storage is built.

Decomposition:
- Package duck_hunt_pkg holds: SPRITE_LEN=13, the phase-0 and phase-1 offset constants, and the state encodings IDLE/LATCH/ERASE/DRAW/DONE.
- One sub-module, bird_sprite_rom: combinational lookup (k, phase) -> (dx, dy), signed 4-bit each.

Test Plan:
- Reset, NUM_BIRDS=4, mask=0001, bird0=(80,60), start. Required:
  - no BG pixels;
  - FG pixels in order (80,60) (80,61) (79,60) (78,60) (77,60) (76,60) (75,60) (77,61) (77,59) (76,62) (76,58) (75,63) (75,57);
  - done at E0+2+4+16 = E0+22.
- Second frame with bird0=(81,60). Required: 13 BG pixels at the old (80,60) footprint, then 13 FG pixels at (81,60); done at E0+2+16+16.
- Clip: bird0=(2,1), mask=0001. Required: exactly 4 plot=1 pixels, (2,1) (2,2) (1,1) (0,1); the other 9 cycles have plot=0.
- start pulsed while busy=1. Required: ignored; exactly one done; the new positions from the ignored start are not captured.
- resetn low during DRAW. Required: plot=0, busy=0 and done=0 immediately. Next frame with mask=0001: zero BG pixels.
- WING_FLAP_EN defined, two frames at (80,60). Required: second draw pixel 9 = (78,62); erase in frame 3 uses the same phase-1 footprint.
